// File: rtl/twos_addsub_pkg.sv
// Shared definitions for the pipelined two's-complement adder/subtractor.
package twos_addsub_pkg;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } op_e;

  // Saturation constants for widths up to 64 bits; callers truncate to their width.
  function automatic logic [63:0] smax(input int unsigned width);
    smax = (64'd1 << (width - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] smin(input int unsigned width);
    smin = 64'd1 << (width - 1);
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One registered SW-bit slice of the carry-chained adder; forwards operands and partial sum.
module addsub_slice #(
  parameter int unsigned SW = 8,
  parameter int unsigned W  = 16,
  parameter int unsigned K  = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         v_in,
  input  logic         sat_in,
  input  logic         c_in,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  input  logic [W-1:0] r_in,
  output logic         v_out,
  output logic         sat_out,
  output logic         c_out,
  output logic [W-1:0] a_out,
  output logic [W-1:0] b_out,
  output logic [W-1:0] r_out
);

  localparam int unsigned LO = K * SW;

  logic [SW:0]  sum;
  logic [W-1:0] r_next;

  always_comb begin
    sum = {1'b0, a_in[LO +: SW]} + {1'b0, b_in[LO +: SW]} + {{SW{1'b0}}, c_in};
  end

  // Bits of this slice are still zero in r_in, so OR-ing merges the new slice in.
  always_comb begin
    r_next = r_in | (W'(sum[SW-1:0]) << LO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_out   <= 1'b0;
      sat_out <= 1'b0;
      c_out   <= 1'b0;
      a_out   <= '0;
      b_out   <= '0;
      r_out   <= '0;
    end else if (en) begin
      v_out   <= v_in;
      sat_out <= sat_in;
      c_out   <= sum[SW];
      a_out   <= a_in;
      b_out   <= b_in;
      r_out   <= r_next;
    end
  end

endmodule

// File: rtl/twos_addsub_pipe.sv
// Pipelined two's-complement add/sub with valid/ready handshake, flags and optional saturation.
module twos_addsub_pipe
  import twos_addsub_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             m,
  input  logic             sat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int unsigned SW  = WIDTH / STAGES;
  localparam int unsigned MSB = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));

  logic             adv;
  logic             v_p   [STAGES];
  logic             sat_p [STAGES];
  logic             c_p   [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] b_p   [STAGES];
  logic [WIDTH-1:0] r_p   [STAGES];

  logic             sub;
  logic [WIDTH-1:0] beff;
  logic             ceff;

  assign adv      = out_ready || !out_valid;
  assign in_ready = adv;

  assign sub  = (m == OP_SUB);
  assign beff = sub ? ~b : b;
  assign ceff = sub ? ~cin : cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic             v_i, sat_i, c_i;
    logic [WIDTH-1:0] a_i, b_i, r_i;

    if (k == 0) begin : g_first
      assign v_i   = in_valid;
      assign sat_i = sat;
      assign c_i   = ceff;
      assign a_i   = a;
      assign b_i   = beff;
      assign r_i   = '0;
    end else begin : g_next
      assign v_i   = v_p[k-1];
      assign sat_i = sat_p[k-1];
      assign c_i   = c_p[k-1];
      assign a_i   = a_p[k-1];
      assign b_i   = b_p[k-1];
      assign r_i   = r_p[k-1];
    end

    addsub_slice #(
      .SW (SW),
      .W  (WIDTH),
      .K  (k)
    ) u_slice (
      .clk     (clk),
      .rst_n   (rst_n),
      .en      (adv),
      .v_in    (v_i),
      .sat_in  (sat_i),
      .c_in    (c_i),
      .a_in    (a_i),
      .b_in    (b_i),
      .r_in    (r_i),
      .v_out   (v_p[k]),
      .sat_out (sat_p[k]),
      .c_out   (c_p[k]),
      .a_out   (a_p[k]),
      .b_out   (b_p[k]),
      .r_out   (r_p[k])
    );
  end

  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] a_last;
  logic [WIDTH-1:0] b_last;

  assign raw       = r_p[STAGES-1];
  assign a_last    = a_p[STAGES-1];
  assign b_last    = b_p[STAGES-1];
  assign out_valid = v_p[STAGES-1];
  assign cout      = c_p[STAGES-1];

  always_comb begin
    ovf = (a_last[MSB] == b_last[MSB]) && (raw[MSB] != a_last[MSB]);
    s   = raw;
    if (sat_p[STAGES-1] && ovf) begin
      s = a_last[MSB] ? SMIN : SMAX;
    end
    // Gated by valid so the cleared pipeline reports zero=0 out of reset.
    zero = out_valid && (s == '0);
    neg  = s[MSB];
  end

endmodule
